// File: rtl/mem_arbiter.sv
// mem_arbiter: shares a word-wide single-port RAM between fetch and load/store,
// with round-robin arbitration, read-modify-write sub-word stores and extending loads.
module mem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  i_valid,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [1:0]            d_size,
    input  logic                  d_unsigned,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_valid,
    output logic                  d_err,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_in,
    output logic                  ram_wen,
    input  logic [DATA_WIDTH-1:0] ram_out
);
    typedef enum logic [2:0] {IDLE, I_RD, D_RD, D_WR, D_RMW, D_ERR} state_t;
    state_t state, state_nx;
    logic last_d, last_d_nx;
    logic grant_d, grant_i, d_bad;
    logic [1:0] a;
    logic [7:0] lb;
    logic [15:0] lh;
    logic [DATA_WIDTH-1:0] ld, merged;
    assign a = d_addr[1:0];
    assign grant_d = d_req && (!i_req || !last_d);
    assign grant_i = i_req && !grant_d;
    assign d_bad = (d_size == 2'b11) || (d_size == 2'b01 && a[0]) || (d_size == 2'b10 && a != 2'b00);
    assign lb = ram_out[8*a +: 8];
    assign lh = a[1] ? ram_out[31:16] : ram_out[15:0];
    assign ld = d_size == 2'b00 ? {{24{~d_unsigned & lb[7]}}, lb}
              : d_size == 2'b01 ? {{16{~d_unsigned & lh[15]}}, lh}
              : ram_out;
    // Sub-word store: splice new lane(s) into the word read back in the grant cycle
    always_comb begin
        merged = ram_out;
        if (d_size == 2'b00)
            merged[8*a +: 8] = d_wdata[7:0];
        else
            merged[16*a[1] +: 16] = d_wdata[15:0];
    end
    always_comb begin
        state_nx  = state;
        last_d_nx = last_d;
        i_rdata   = '0;
        i_valid   = 1'b0;
        d_rdata   = '0;
        d_valid   = 1'b0;
        d_err     = 1'b0;
        ram_addr  = '0;
        ram_in    = '0;
        ram_wen   = 1'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    last_d_nx = 1'b1;
                    if (d_bad) begin
                        state_nx = D_ERR;
                    end else begin
                        ram_addr = d_addr;
                        if (!d_we) begin
                            state_nx = D_RD;
                        end else if (d_size == 2'b10) begin
                            ram_in   = d_wdata;
                            ram_wen  = 1'b1;
                            state_nx = D_WR;
                        end else begin
                            state_nx = D_RMW;
                        end
                    end
                end else if (grant_i) begin
                    last_d_nx = 1'b0;
                    ram_addr  = i_addr;
                    state_nx  = I_RD;
                end
            end
            I_RD: begin
                i_valid  = 1'b1;
                i_rdata  = ram_out;
                state_nx = IDLE;
            end
            D_RD: begin
                d_valid  = 1'b1;
                d_rdata  = ld;
                state_nx = IDLE;
            end
            D_WR: begin
                d_valid  = 1'b1;
                state_nx = IDLE;
            end
            D_RMW: begin
                ram_addr = d_addr;
                ram_in   = merged;
                ram_wen  = 1'b1;
                d_valid  = 1'b1;
                state_nx = IDLE;
            end
            D_ERR: begin
                d_valid  = 1'b1;
                d_err    = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Reset silences everything, including a pending read-modify-write
        if (rst) begin
            i_rdata  = '0;
            i_valid  = 1'b0;
            d_rdata  = '0;
            d_valid  = 1'b0;
            d_err    = 1'b0;
            ram_addr = '0;
            ram_in   = '0;
            ram_wen  = 1'b0;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            last_d <= 1'b0;
        end else begin
            state  <= state_nx;
            last_d <= last_d_nx;
        end
    end
endmodule
